// File: rtl/flag_unit.sv
// flag_unit -- x86 flag-control unit (CLC/STC/CMC/CLD/STD/LAHF/SAHF).
//
// Commands from decode are queued in a small circular FIFO. Each popped
// command updates the architectural status/DF registers and loads one
// registered result beat for the AH/status writeback path. An ALU-side
// load port overwrites the status and stalls execution for that cycle.
//
// Build option: define FLAG_UNIT_DF_EN to track the direction flag. Without it
// df_q/out_df are tied to 0 and CLD/STD behave as unknown opcodes.
//
// Opcode encoding (in_opc): CLC=0, STC=1, CMC=2, CLD=3, STD=4, LAHF=5,
// SAHF=6; anything else is a no-op that still produces a result beat.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/in_opc/in_ah   command queue input
//   ld_valid/ld_status         ALU status load
//   out_valid/out_ready        result beat handshake
//   out_ah_wr/out_ah/out_status/out_df   result beat fields
//   status_q/df_q              live architectural flags
//   q_count                    queued command count
// Status layout: [0] PF [1] ZF [2] SF [3] OF [4] CF [5] AF.

module flag_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opc,
    input  logic [7:0]       in_ah,
    input  logic             ld_valid,
    input  logic [5:0]       ld_status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ah_wr,
    output logic [7:0]       out_ah,
    output logic [5:0]       out_status,
    output logic             out_df,
    output logic [5:0]       status_q,
    output logic             df_q,
    output logic [CNT_W-1:0] q_count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [5:0] CMD_CLC  = 6'd0;
    localparam logic [5:0] CMD_STC  = 6'd1;
    localparam logic [5:0] CMD_CMC  = 6'd2;
    localparam logic [5:0] CMD_CLD  = 6'd3;
    localparam logic [5:0] CMD_STD  = 6'd4;
    localparam logic [5:0] CMD_LAHF = 6'd5;
    localparam logic [5:0] CMD_SAHF = 6'd6;

    localparam int PF = 0, ZF = 1, SF = 2, CF = 4, AF = 5;

    logic [5:0]    opc_mem [FIFO_DEPTH];
    logic [7:0]    ah_mem  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic       push, pop;
    logic [5:0] head_opc;
    logic [7:0] head_ah;
    logic [5:0] status_d;
    logic [7:0] ah_d;
    logic       ah_wr_d;
    logic       df_cur;
    logic       df_d;

    // in_ready looks only at the registered count: no path from out_ready.
    assign in_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    // Result register must be free (or draining) and no ALU load this cycle.
    assign pop      = (count_q != '0) & (~out_valid | out_ready) & ~ld_valid;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign q_count  = count_q;

    assign head_opc = opc_mem[rd_ptr_q];
    assign head_ah  = ah_mem[rd_ptr_q];

`ifdef FLAG_UNIT_DF_EN
    logic df_r;
    assign df_cur = df_r;
    assign df_q   = df_r;
`else
    assign df_cur = 1'b0;
    assign df_q   = 1'b0;
`endif

    // Post-command flag values for the command at the queue head.
    always_comb begin
        status_d = status_q;
        df_d     = df_cur;
        ah_d     = head_ah;
        ah_wr_d  = 1'b0;
        case (head_opc)
            CMD_CLC: status_d[CF] = 1'b0;
            CMD_STC: status_d[CF] = 1'b1;
            CMD_CMC: status_d[CF] = ~status_q[CF];
`ifdef FLAG_UNIT_DF_EN
            CMD_CLD: df_d = 1'b0;
            CMD_STD: df_d = 1'b1;
`endif
            CMD_LAHF: begin
                ah_d    = {status_q[SF], status_q[ZF], 1'b0, status_q[AF],
                           1'b0, status_q[PF], 1'b1, status_q[CF]};
                ah_wr_d = 1'b1;
            end
            CMD_SAHF: begin
                status_d[SF] = head_ah[7];
                status_d[ZF] = head_ah[6];
                status_d[AF] = head_ah[4];
                status_d[PF] = head_ah[2];
                status_d[CF] = head_ah[0];
            end
            default: ;
        endcase
    end

    // Queue storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            opc_mem[wr_ptr_q] <= in_opc;
            ah_mem[wr_ptr_q]  <= in_ah;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            status_q   <= '0;
            out_valid  <= 1'b0;
            out_ah_wr  <= 1'b0;
            out_ah     <= '0;
            out_status <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ld_valid)  status_q <= ld_status;
            else if (pop)  status_q <= status_d;
            if (pop) begin
                out_valid  <= 1'b1;
                out_ah_wr  <= ah_wr_d;
                out_ah     <= ah_d;
                out_status <= status_d;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

`ifdef FLAG_UNIT_DF_EN
    logic out_df_r;
    assign out_df = out_df_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            df_r     <= 1'b0;
            out_df_r <= 1'b0;
        end else if (pop) begin
            df_r     <= df_d;
            out_df_r <= df_d;
        end
    end
`else
    assign out_df = 1'b0;
`endif

endmodule

// File: doc/flag_unit.md
# flag_unit

Sequential, parametrised flag-control unit that executes the x86 flag-manipulation commands on an internal architectural flag register. Covers CLC, STC, CMC, CLD, STD, LAHF and SAHF. Commands arrive from decode through a valid/ready command queue; each retired command emits one registered result beat. An ALU-side load port overwrites the compressed status. The unit sits between decode and the AH/status writeback path of the execute stage.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: command queue entries; power of two, ≥ 2.
- `CNT_W`, default 3: width of `q_count`; must equal clog2(FIFO_DEPTH)+1.

Ports (clock and reset first):
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command present.
- `in_ready` out 1: queue can accept a command.
- `in_opc` in 6: command opcode, `CMD_*` encoding.
- `in_ah` in 8: AH operand, used by SAHF.
- `ld_valid` in 1: ALU status load request.
- `ld_status` in 6: status value to load.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: consumer accepts the result beat.
- `out_ah_wr` out 1: result writes AH; set only for LAHF.
- `out_ah` out 8: AH value to write.
- `out_status` out 6: status after the command.
- `out_df` out 1: direction flag after the command.
- `status_q` out 6: live architectural status.
- `df_q` out 1: live direction flag.
- `q_count` out CNT_W: number of queued commands.

## Operation
- **Status layout:** [0] PF, [1] ZF, [2] SF, [3] OF, [4] CF, [5] AF.
- **Queue:** circular FIFO of {opc, ah}.
  - `in_ready` = (q_count < FIFO_DEPTH).
  - A push occurs on `in_valid & in_ready`.
  - There is no bypass: a push into an empty queue is not executed in the same cycle.
- **Execute/pop condition:** queue non-empty AND (`!out_valid` OR `out_ready`) AND `!ld_valid`.
- **Effect of each command on pop:**
  - CLC: CF←0.
  - STC: CF←1.
  - CMC: CF←~CF.
  - CLD: DF←0.
  - STD: DF←1.
  - LAHF: out_ah = {SF, ZF, 0, AF, 0, PF, 1, CF}; `out_ah_wr`=1; flags unchanged.
  - SAHF: SF, ZF, AF, PF, CF ← in_ah[7], [6], [4], [2], [0]; OF unchanged.
  - Any other opcode: no flag change, `out_ah_wr`=0. It still produces a result beat.
- **Result beat:**
  - On pop, the output register loads the post-command `status_q`/`df_q`, `out_ah_wr`, and `out_ah`.
  - `out_ah` is the command's `in_ah` for non-LAHF commands.
  - `out_valid` is set on pop.
  - `out_valid` clears on `out_ready` when no pop occurs in the same cycle.
  - `out_valid` holds while `out_ready`=0.
  - Output fields are stable while `out_valid & !out_ready`.
- **ALU load:** `ld_valid` forces `status_q`←`ld_status` and leaves `df_q` unchanged. Execution is stalled that cycle; pushes are still accepted.
- **Simultaneous push and pop:** `q_count` is unchanged; pointers wrap modulo FIFO_DEPTH.
- **Mid-operation reset:** assertion of `rst_n`=0 discards queued commands and any pending result beat immediately.

## Timing
- **Reset values:**
  - `in_ready`=1.
  - `out_valid`=0, `out_ah_wr`=0.
  - `out_ah`=8'h00, `out_status`=6'h00, `out_df`=0.
  - `status_q`=6'h00, `df_q`=0, `q_count`=0.
- **Latency:** for a command pushed at edge E into an empty queue with `out_ready`=1, the pop occurs at edge E+1 and `out_valid` is high after E+1.
- **Throughput:** one command per cycle with `out_ready` held high.
- **Architectural state visibility:** `status_q`/`df_q` change at the pop edge, the same edge that loads the result beat.
- **Loads:** a load at edge E is visible on `status_q` after E; the next popped command operates on the loaded value.
- **Combinational paths:** `in_ready` depends only on `q_count`, with no combinational path from `out_ready`.

## Configuration
- **`FLAG_UNIT_DF_EN` defined:** the direction flag is tracked as described above.
- **`FLAG_UNIT_DF_EN` undefined:**
  - No DF register exists; `df_q` and `out_df` are tied to 0.
  - CLD and STD are treated as unknown opcodes: no flag change, a result beat is still produced.

## Test plan
- **Reset, then single STC:** push STC with status 6'h00 → one beat with `out_status`=6'h10, `out_ah_wr`=0; `status_q`=6'h10.
- **LAHF:** `ld_status`=6'h3F, then push LAHF → `out_ah`=8'hD7, `out_ah_wr`=1; `status_q` stays 6'h3F.
- **SAHF:** push SAHF with `in_ah`=8'h41 from status 6'h08 → `out_status`=6'h1A (OF kept, ZF=1, CF=1, others 0).
- **Backpressure:** hold `out_ready`=0 and push 5 commands (DEPTH 4) → 1 beat held in the output register, queue holds 4 with `q_count`=4 and `in_ready`=0. Then release `out_ready` → beats drain in order, one per cycle.
- **Load stall:** `ld_valid`=1 for 2 cycles with CMC queued → no pop during the load cycles. Afterwards CMC operates on `ld_status`: from 6'h10, `out_status`=6'h00.
- **CLD/STD:** STD then CLD → with `FLAG_UNIT_DF_EN`, `out_df` is 1 then 0; without it, `out_df` is 0 for both beats.
